// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a length-prefixed big-endian byte stream,
// assembles 32-bit words, writes them to instruction memory, then releases the CPU.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              cpu_run,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, CHECK, BYTES, WRITE, DONE, ERR
  } state_t;

  localparam logic [32:0]   CAPACITY  = 33'd1 << ADDR_W;
  localparam logic [ADDR_W:0] COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t          r_state;
  state_t          w_state_next;
  logic [15:0]     r_len;
  logic [31:0]     r_word;
  logic [1:0]      r_byte_idx;
  logic [ADDR_W:0] r_count;

  logic            w_xfer;
  logic            w_restart;
  logic            w_len_zero;
  logic            w_len_over;
  logic            w_last_word;
  logic [ADDR_W:0] w_count_inc;

  // Outputs are pure functions of registered state, so reset values appear
  // asynchronously and byte_ready never looks at byte_valid.
  assign byte_ready = (r_state == LEN_HI) || (r_state == LEN_LO) || (r_state == BYTES);
  assign im_we      = (r_state == WRITE);
  assign im_addr    = r_count[ADDR_W-1:0];
  assign im_wdata   = r_word;
  assign word_count = r_count;
  assign busy       = !((r_state == IDLE) || (r_state == DONE) || (r_state == ERR));
  assign cpu_run    = (r_state == DONE);
  assign err        = (r_state == ERR);

  assign w_xfer      = byte_valid && byte_ready;
  assign w_restart   = start && !busy;
  assign w_len_zero  = (r_len == 16'd0);
  assign w_len_over  = ({17'd0, r_len} > CAPACITY);
  assign w_count_inc = r_count + COUNT_ONE;
  // count is one bit wider than the address so N = 2^ADDR_W completes without wrapping
  assign w_last_word = ({{(32-ADDR_W){1'b0}}, w_count_inc} == {17'd0, r_len});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, DONE, ERR: if (start) w_state_next = LEN_HI;
      LEN_HI:          if (w_xfer) w_state_next = LEN_LO;
      LEN_LO:          if (w_xfer) w_state_next = CHECK;
      CHECK: begin
        if (w_len_zero) begin
          w_state_next = DONE;
        end else if (w_len_over) begin
          w_state_next = ERR;
        end else begin
          w_state_next = BYTES;
        end
      end
      BYTES:           if (w_xfer && (r_byte_idx == 2'd3)) w_state_next = WRITE;
      WRITE:           w_state_next = w_last_word ? DONE : BYTES;
      default:         w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len      <= 16'd0;
      r_word     <= 32'd0;
      r_byte_idx <= 2'd0;
      r_count    <= '0;
    end else begin
      if (w_restart) begin
        r_count <= '0;
      end
      if ((r_state == LEN_HI) && w_xfer) begin
        r_len[15:8] <= byte_data;
      end
      if ((r_state == LEN_LO) && w_xfer) begin
        r_len[7:0] <= byte_data;
      end
      if (r_state == CHECK) begin
        r_byte_idx <= 2'd0;
      end
      // MSB arrives first, so shifting left leaves the first byte on top
      if ((r_state == BYTES) && w_xfer) begin
        r_word     <= {r_word[23:0], byte_data};
        r_byte_idx <= r_byte_idx + 2'd1;
      end
      if (r_state == WRITE) begin
        r_count <= w_count_inc;
      end
    end
  end

endmodule
